// File: rtl/nfa_stream_feeder.sv
// Byte-stream feeder for a bank of NFA match engines: buffers host bytes, frames
// each packet with a start-of-data pulse and LAT pad beats, then reports the match result.
module nfa_stream_feeder #(
  parameter int          DEPTH = 8,
  parameter int          LAT   = 2,
  parameter logic [7:0]  PAD   = 8'h00,
  parameter int          LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic [7:0]       char,
  output logic             en,
  output logic             sod,
  input  logic             match,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_match,
  output logic [LEN_W-1:0] res_len
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = (LAT < 1) ? 1 : $clog2(LAT + 1);
  localparam logic [DW-1:0] LAT_C = DW'(LAT);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    REPORT = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [7:0]       char_q, char_d;
  logic             en_q, en_d;
  logic             sod_q, sod_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic             res_valid_q, res_valid_d;
  logic             res_match_q, res_match_d;
  logic [LEN_W-1:0] res_len_q, res_len_d;

  logic [8:0] mem [DEPTH];
  logic [8:0] head;
  logic       fifo_empty;
  logic       fifo_full;
  logic       push;
  logic       pop;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign in_ready   = ~fifo_full;
  assign push       = in_valid & ~fifo_full;
  assign head       = mem[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q[AW-1:0]] <= {in_last, in_data};
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
  end

  always_comb begin
    state_d     = state_q;
    char_d      = char_q;
    en_d        = 1'b0;
    sod_d       = 1'b0;
    len_d       = len_q;
    drain_d     = drain_q;
    res_valid_d = res_valid_q;
    res_match_d = res_match_q;
    res_len_d   = res_len_q;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = START;
          sod_d   = 1'b1;
        end
      end
      START: begin
        state_d = STREAM;
      end
      STREAM: begin
        if (!fifo_empty) begin
          pop    = 1'b1;
          char_d = head[7:0];
          en_d   = 1'b1;
          len_d  = (&len_q) ? len_q : len_q + LEN_W'(1);
          if (head[8]) begin
            state_d = DRAIN;
            drain_d = '0;
          end
        end
      end
      DRAIN: begin
        // Pad beats issued while counting; the count reaches LAT in the cycle
        // the last pad is on the bus, which is when match reflects the last byte.
        if (drain_q == LAT_C) begin
          state_d     = REPORT;
          res_valid_d = 1'b1;
          res_match_d = match;
          res_len_d   = len_q;
        end else begin
          drain_d = drain_q + DW'(1);
          char_d  = PAD;
          en_d    = 1'b1;
        end
      end
      REPORT: begin
        if (res_ready) begin
          state_d     = IDLE;
          res_valid_d = 1'b0;
          len_d       = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      char_q      <= '0;
      en_q        <= 1'b0;
      sod_q       <= 1'b0;
      len_q       <= '0;
      drain_q     <= '0;
      res_valid_q <= 1'b0;
      res_match_q <= 1'b0;
      res_len_q   <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      char_q      <= char_d;
      en_q        <= en_d;
      sod_q       <= sod_d;
      len_q       <= len_d;
      drain_q     <= drain_d;
      res_valid_q <= res_valid_d;
      res_match_q <= res_match_d;
      res_len_q   <= res_len_d;
    end
  end

  assign char      = char_q;
  assign en        = en_q;
  assign sod       = sod_q;
  assign res_valid = res_valid_q;
  assign res_match = res_match_q;
  assign res_len   = res_len_q;

endmodule
